// File: rtl/bram_bitrev_ctrl.sv
// Loads a 64-word frame into a dual-port RAM in natural order through port A.
// It then streams the frame out of port B in bit-reversed address order, with valid/ready flow control.
module bram_bitrev_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             frame_done_o,
    output logic             en_o,
    output logic             we_a_o,
    output logic [5:0]       addr_a_o,
    output logic [WIDTH-1:0] di_a_o,
    output logic             we_b_o,
    output logic [5:0]       addr_b_o,
    output logic [WIDTH-1:0] di_b_o,
    input  logic [WIDTH-1:0] do_b_i
);

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_UNLOAD = 1'b1
    } state_t;

    state_t     state_q;
    logic [6:0] wr_cnt_q;
    logic [6:0] rd_cnt_q;
    logic [5:0] out_cnt_q;
    logic       out_valid_q;
    logic       frame_done_q;

    logic       wr_hs_s;
    logic       rd_issue_s;
    logic       out_hs_s;
    logic       last_hs_s;

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = a[5-i];
        end
        return r;
    endfunction

    // Handshake and read-issue qualifiers; a read is issued only when the output slot is free or draining.
    always_comb begin
        wr_hs_s    = (state_q == ST_LOAD) && rst_ni && in_valid_i;
        rd_issue_s = (state_q == ST_UNLOAD) && !rd_cnt_q[6] && (!out_valid_q || out_ready_i);
        out_hs_s   = out_valid_q && out_ready_i;
        last_hs_s  = out_hs_s && (out_cnt_q == 6'd63);
    end

    // RAM port and stream output drive; DO_B holds while En is low, so it doubles as the output buffer.
    always_comb begin
        in_ready_o   = (state_q == ST_LOAD) && rst_ni;
        en_o         = wr_hs_s || rd_issue_s;
        we_a_o       = wr_hs_s;
        addr_a_o     = wr_cnt_q[5:0];
        di_a_o       = in_data_i;
        we_b_o       = 1'b0;
        addr_b_o     = bitrev6(rd_cnt_q[5:0]);
        di_b_o       = {WIDTH{1'b0}};
        out_data_o   = do_b_i;
        out_valid_o  = out_valid_q;
        out_last_o   = out_valid_q && (out_cnt_q == 6'd63);
        frame_done_o = frame_done_q;
    end

    // Frame FSM with write, read-issue and output counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_LOAD;
            wr_cnt_q     <= 7'd0;
            rd_cnt_q     <= 7'd0;
            out_cnt_q    <= 6'd0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_hs_s;
            case (state_q)
                ST_LOAD: begin
                    if (wr_hs_s) begin
                        if (wr_cnt_q == 7'd63) begin
                            wr_cnt_q <= 7'd0;
                            state_q  <= ST_UNLOAD;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 7'd1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (rd_issue_s) begin
                        rd_cnt_q    <= rd_cnt_q + 7'd1;
                        out_valid_q <= 1'b1;
                    end else if (out_hs_s) begin
                        out_valid_q <= 1'b0;
                    end
                    if (last_hs_s) begin
                        out_cnt_q <= 6'd0;
                        rd_cnt_q  <= 7'd0;
                        state_q   <= ST_LOAD;
                    end else if (out_hs_s) begin
                        out_cnt_q <= out_cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bitrev_ctrl.sv
// Bench for bram_bitrev_ctrl: behavioural RAM, a frame-level reference model,
// directed vector table, and randomized frames with varied input/output flow control.
module tb_bram_bitrev_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        frame_done;
    logic        en;
    logic        we_a;
    logic [5:0]  addr_a;
    logic [31:0] di_a;
    logic        we_b;
    logic [5:0]  addr_b;
    logic [31:0] di_b;
    logic [31:0] do_b;

    bram_bitrev_ctrl #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .frame_done_o(frame_done),
        .en_o(en), .we_a_o(we_a), .addr_a_o(addr_a), .di_a_o(di_a),
        .we_b_o(we_b), .addr_b_o(addr_b), .di_b_o(di_b), .do_b_i(do_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with a shared enable; read data registered and held while disabled.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (en) begin
            if (we_a) mem[addr_a] <= di_a;
            if (we_b) mem[addr_b] <= di_b;
            do_b <= mem[addr_b];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        ld;
    int          wr_idx;
    logic [31:0] frame [64];
    logic [31:0] exp_q [$];
    logic        pend_fd;
    logic        prev_valid, prev_ordy;
    logic [31:0] prev_data;
    int          unload_age;
    int          unload_cycles;
    int          frames_done;
    int          hs_total;
    int          cyc;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        exp_rdy;
        logic        exp_en;
        logic        exp_we;
        logic [5:0]  exp_addr;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int i);
        int r = 0;
        for (int b = 0; b < 6; b++) r += ((i / (1 << b)) % 2) * (32 / (1 << b));
        return r;
    endfunction

    task automatic model_reset();
        ld = 1'b1; wr_idx = 0; exp_q.delete(); pend_fd = 1'b0;
        prev_valid = 1'b0; prev_ordy = 1'b0; prev_data = 32'd0;
        unload_age = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_we_a", we_a, 1'b0);
        chk("rst_we_b", we_b, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        in_valid = 1'b1;
        #1;
        chk("rst_en_with_valid", en, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs after the falling edge, then check against the model.
    task automatic tick(input logic iv, input logic [31:0] id, input logic ordy);
        logic ld_next;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        cyc++;
        ld_next = ld;
        chk("in_ready", in_ready, ld);
        chk("frame_done", frame_done, pend_fd);
        pend_fd = 1'b0;
        chk("we_b", we_b, 1'b0);
        chk("di_b", di_b, 32'd0);
        chk("out_last", out_last, !ld && out_valid && (exp_q.size() == 1));
        if (ld) begin
            chk("out_valid_load", out_valid, 1'b0);
            if (iv) begin
                chk("wr_en", en, 1'b1);
                chk("wr_we_a", we_a, 1'b1);
                chk("wr_addr_a", addr_a, wr_idx);
                chk("wr_di_a", di_a, id);
                frame[wr_idx] = id;
                wr_idx++;
                if (wr_idx == 64) begin
                    for (int k = 0; k < 64; k++) exp_q.push_back(frame[bitrev(k)]);
                    wr_idx = 0;
                    ld_next = 1'b0;
                    unload_age = 0;
                    unload_cycles = 0;
                end
            end else begin
                chk("idle_en", en, 1'b0);
                chk("idle_we_a", we_a, 1'b0);
            end
        end else begin
            chk("unload_we_a", we_a, 1'b0);
            if (unload_age == 0) chk("unload_entry_valid", out_valid, 1'b0);
            if (unload_age == 1) chk("first_valid_latency", out_valid, 1'b1);
            if (prev_valid && !prev_ordy) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && ordy) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    chk("extra_output", 1'b1, 1'b0);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        pend_fd = 1'b1;
                        ld_next = 1'b1;
                        frames_done++;
                    end
                end
            end
            unload_age++;
            unload_cycles++;
        end
        prev_valid = out_valid; prev_ordy = ordy; prev_data = out_data;
        ld = ld_next;
    endtask

    // imode: 0 always valid, 1 every 3rd cycle, 2 random; omode: 0 ready=1, 1 toggle, 2 random.
    // base >= 0 loads base+i, otherwise random data; stop_after > 0 aborts after that many outputs.
    task automatic run_frame(input int imode, input int omode, input int base, input int stop_after);
        int start_fd = frames_done;
        int start_hs = hs_total;
        int budget = 0;
        int sent = 0;
        int local_cyc = 0;
        logic iv, ordy;
        logic [31:0] d;
        while (frames_done == start_fd && budget < 3000 &&
               !(stop_after > 0 && hs_total - start_hs >= stop_after)) begin
            case (imode)
                0:       iv = 1'b1;
                1:       iv = (local_cyc % 3 == 0);
                default: iv = 1'($urandom_range(0, 1));
            endcase
            case (omode)
                0:       ordy = 1'b1;
                1:       ordy = (local_cyc % 2 == 0);
                default: ordy = 1'($urandom_range(0, 1));
            endcase
            if (ld) d = (base >= 0) ? 32'(base + sent) : $urandom;
            else d = 32'hDEAD;
            if (ld && iv) sent++;
            if (!ld && imode == 0) iv = 1'b1;
            tick(iv, d, ordy);
            budget++;
            local_cyc++;
        end
        if (budget >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL frame_timeout: %0d outputs seen, required frame completion", hs_total - start_hs);
        end else if (stop_after <= 0) begin
            tick(1'b0, 32'd0, 1'b1);
            if (omode == 0) chk("unload_cycle_count", unload_cycles, 65);
            chk("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        cyc = 0; frames_done = 0; hs_total = 0; unload_cycles = 0;
        model_reset();
        tbl[0] = '{1'b1, 32'hA0, 1'b1, 1'b1, 1'b1, 6'd0};
        tbl[1] = '{1'b0, 32'hFF, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[2] = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b1, 6'd1};
        tbl[3] = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 6'd2};
        tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 6'd3};
        tbl[5] = '{1'b0, 32'h11, 1'b1, 1'b0, 1'b0, 6'd3};
        tbl[6] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 6'd3};
        tbl[7] = '{1'b1, 32'hA4, 1'b1, 1'b1, 1'b1, 6'd4};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = 1'b1;
            #1;
            chk("tbl_in_ready", in_ready, tbl[i].exp_rdy);
            chk("tbl_en", en, tbl[i].exp_en);
            chk("tbl_we_a", we_a, tbl[i].exp_we);
            if (tbl[i].exp_we) begin
                chk("tbl_addr_a", addr_a, tbl[i].exp_addr);
                chk("tbl_di_a", di_a, tbl[i].id);
            end
            chk("tbl_out_valid", out_valid, 1'b0);
        end
        do_reset();

        run_frame(0, 0, 100, 0);
        run_frame(0, 1, 100, 0);
        run_frame(0, 0, 5000, 0);
        run_frame(1, 0, 700, 0);
        run_frame(0, 2, -1, 0);
        run_frame(0, 0, 300, 10);
        do_reset();
        run_frame(0, 0, 900, 0);
        for (int f = 0; f < 3; f++) run_frame(2, 2, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_bitrev_ctrl.md
BRAM_BITREV_CTRL -- requirements
Module: bram_bitrev_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, data word width; memory depth fixed at 64 words (6-bit address).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 In_Valid  input  1  input sample valid.
REQ-005 In_Ready  output  1  block accepts an input sample this cycle.
REQ-006 In_Data  input  WIDTH  input sample, natural order.
REQ-007 Out_Valid  output  1  output sample valid.
REQ-008 Out_Ready  input  1  downstream accepts the output sample.
REQ-009 Out_Data  output  WIDTH  output sample, bit-reversed order.
REQ-010 Out_Last  output  1  marks the 64th output sample of a frame.
REQ-011 Frame_Done  output  1  one-cycle pulse after the last output handshake.
REQ-012 En  output  1  dual-port RAM enable, shared by both ports.
REQ-013 We_A  output  1  RAM port A write enable.
REQ-014 Addr_A  output  6  RAM port A address.
REQ-015 DI_A  output  WIDTH  RAM port A write data.
REQ-016 We_B  output  1  RAM port B write enable, constant 0.
REQ-017 Addr_B  output  6  RAM port B address.
REQ-018 DI_B  output  WIDTH  RAM port B write data, constant 0.
REQ-019 DO_B  input  WIDTH  RAM port B read data, valid 1 cycle after an En-qualified read; holds while En=0.

Function
REQ-020 Two states, LOAD and UNLOAD; a 7-bit write counter wr_cnt and a 7-bit read-issue counter rd_cnt.
REQ-021 LOAD: In_Ready=1; a handshake (In_Valid&&In_Ready) drives En=1, We_A=1, Addr_A=wr_cnt[5:0], DI_A=In_Data, and increments wr_cnt.
REQ-022 LOAD with no handshake: En=0, We_A=0; Addr_A/DI_A don't-care.
REQ-023 Handshake with wr_cnt=63 writes address 63, clears wr_cnt, moves to UNLOAD next cycle.
REQ-024 UNLOAD: In_Ready=0; In_Valid ignored, no write issued.
REQ-025 UNLOAD read issue when rd_cnt<64 and (Out_Valid=0 or Out_Ready=1): En=1, We_B=0, Addr_B=bit-reverse(rd_cnt[5:0]) (bit i -> bit 5-i), rd_cnt increments.
REQ-026 No read issue: En=0, so DO_B holds the pending word.
REQ-027 Out_Data=DO_B combinationally; Out_Valid registered: set on cycle after an issue, cleared on handshake with no issue in the same cycle.
REQ-028 Latency: first Out_Valid one cycle after UNLOAD entry; with Out_Ready held 1, one sample per cycle, 64 consecutive cycles.
REQ-029 Out_Last=1 iff Out_Valid=1 and the presented word is the 64th of the frame (output counter=63).
REQ-030 Handshake with Out_Last=1: Frame_Done=1 next cycle, rd_cnt and output counter cleared, state returns to LOAD same next cycle.
REQ-031 Out_Data/Out_Valid stable while Out_Valid=1 and Out_Ready=0.
REQ-032 Port A idle (We_A=0) in UNLOAD; port B idle (En only for reads) in LOAD; never simultaneous write and read.

Reset
REQ-033 Rst_n=0 asynchronously forces: state LOAD, wr_cnt=0, rd_cnt=0, output counter=0, Out_Valid=0, Frame_Done=0.
REQ-034 During reset outputs: In_Ready=1 after release only; En=0, We_A=0, We_B=0, Out_Last=0.
REQ-035 Reset mid-frame abandons the frame; RAM contents are not cleared; next frame starts at address 0.

Verification
REQ-036 Load In_Data=100+i for i=0..63, Out_Ready=1 -> outputs 100,132,116,148,108,... (100+bitrev(i)), Out_Last on 64th (value 163), Frame_Done pulse next cycle, In_Ready=1 after.
REQ-037 Out_Ready toggling 1/0 each cycle in UNLOAD -> no dropped/duplicated words, Out_Data stable during stalls, sequence as REQ-036.
REQ-038 In_Valid=1 throughout UNLOAD with In_Data=0xDEAD -> In_Ready=0, We_A never 1, output sequence unaffected.
REQ-039 Gapped input (In_Valid 1 every 3rd cycle) -> 64 writes to addresses 0..63 in order, UNLOAD entered only after the 64th.
REQ-040 Rst_n pulsed low after 10 outputs -> Out_Valid=0 immediately, In_Ready=1 after release, new frame loads from address 0 and unloads correctly.
REQ-041 Two back-to-back frames with different data -> second frame output matches its own bit-reversed order, no stale words.
